// File: rtl/bus_control_unit.sv
// Bus control unit: byte-wide prefetch queue, prefetch pointer and
// arbitration of fetch and execution-unit bus cycles on a 16-bit bus.
module bus_control_unit #(
    parameter int QUEUE_DEPTH    = 8,
    parameter int FETCH_FREE_MIN = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   ps,
    input  logic                          flush,
    input  logic [15:0]                   flush_pc,
    input  logic                          suspend,
    input  logic                          q_pop,
    output logic [7:0]                    q_data,
    output logic [$clog2(QUEUE_DEPTH):0]  q_count,
    output logic [15:0]                   pfp,
    input  logic [2:0]                    eu_cmd,
    input  logic [19:0]                   eu_addr,
    input  logic                          eu_word,
    input  logic [15:0]                   eu_wdata,
    output logic [15:0]                   eu_rdata,
    output logic                          eu_done,
    input  logic                          readyb,
    input  logic [15:0]                   data_in,
    output logic [15:0]                   data_out,
    output logic [19:0]                   address_out,
    output logic [3:0]                    bus_status,
    output logic                          bus_ube_n
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] FMIN  = CW'(FETCH_FREE_MIN);
    localparam logic [3:0] ST_IDLE  = 4'hf;
    localparam logic [3:0] ST_MRD   = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EU_LO, S_EU_HI} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [QUEUE_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [15:0]   r_pfp;
    logic          r_fdisc;
    logic [7:0]    r_lo;
    logic          r_eu_done;
    logic [15:0]   r_rdata;
    logic [3:0]    r_status;
    logic [19:0]   r_addr;
    logic [15:0]   r_dout;
    logic          r_ube;

    logic          w_rdy;
    logic          w_done;
    logic          w_arb;
    logic          w_odd_word;
    logic          w_eu_req;
    logic          w_eu_final;
    logic          w_push_ok;
    logic [1:0]    w_push_n;
    logic          w_pop;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_free;
    logic [15:0]   w_pfp_nxt;
    logic          w_can_fetch;
    logic [3:0]    w_eu_status;
    logic [15:0]   w_rdata_nxt;
    logic [3:0]    w_status_nxt;
    logic [19:0]   w_addr_nxt;
    logic [15:0]   w_dout_nxt;
    logic          w_ube_nxt;

    assign w_rdy      = !readyb;
    assign w_done     = (r_state != S_IDLE) && w_rdy;
    assign w_arb      = (r_state == S_IDLE) || w_done;
    assign w_odd_word = eu_word & eu_addr[0];
    assign w_eu_req   = (eu_cmd != 3'd0) && (eu_cmd <= 3'd4);
    assign w_eu_final = w_rdy && (((r_state == S_EU_LO) && !w_odd_word)
                                  || (r_state == S_EU_HI));

    // A fetch overlapped by a flush still finishes on the bus but is dropped
    assign w_push_ok = (r_state == S_FETCH) && w_rdy && !flush && !r_fdisc;
    assign w_push_n  = !w_push_ok ? 2'd0 : (r_pfp[0] ? 2'd1 : 2'd2);
    assign w_pop     = q_pop && (r_count != '0) && !flush;
    assign w_cnt_nxt = flush ? '0
                     : r_count + CW'(w_push_n) - CW'(w_pop);
    assign w_free    = DEPTH - w_cnt_nxt;

    always_comb begin
        w_pfp_nxt = r_pfp;
        if (flush)
            w_pfp_nxt = flush_pc;
        else if (w_push_ok)
            w_pfp_nxt = r_pfp + (r_pfp[0] ? 16'd1 : 16'd2);
    end

    assign w_can_fetch = !suspend && !flush &&
        (w_pfp_nxt[0] ? (w_free != '0) : (w_free >= FMIN));

    always_comb begin
        case (eu_cmd)
            3'd1:    w_eu_status = 4'b1001;
            3'd2:    w_eu_status = 4'b1010;
            3'd3:    w_eu_status = 4'b0101;
            3'd4:    w_eu_status = 4'b0110;
            default: w_eu_status = ST_IDLE;
        endcase
    end

    always_comb begin
        if (r_state == S_EU_HI)
            w_rdata_nxt = {data_in[7:0], r_lo};
        else if (eu_word)
            w_rdata_nxt = data_in;
        else
            w_rdata_nxt = {8'h00, eu_addr[0] ? data_in[15:8] : data_in[7:0]};
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_addr_nxt   = r_addr;
        w_dout_nxt   = r_dout;
        w_ube_nxt    = r_ube;
        if (w_arb) begin
            if ((r_state == S_EU_LO) && w_odd_word) begin
                w_state_nxt = S_EU_HI;
                w_addr_nxt  = eu_addr + 20'd1;
                w_ube_nxt   = 1'b1;
                w_dout_nxt  = {2{eu_wdata[15:8]}};
            end else if (w_eu_req && !w_eu_final) begin
                w_state_nxt  = S_EU_LO;
                w_status_nxt = w_eu_status;
                w_addr_nxt   = eu_addr;
                w_ube_nxt    = !(eu_word | eu_addr[0]);
                w_dout_nxt   = (eu_word && !eu_addr[0]) ? eu_wdata
                                                        : {2{eu_wdata[7:0]}};
            end else if (w_can_fetch) begin
                w_state_nxt  = S_FETCH;
                w_status_nxt = ST_MRD;
                w_addr_nxt   = {ps, 4'h0} + {4'h0, w_pfp_nxt};
                w_ube_nxt    = 1'b0;
            end else begin
                w_state_nxt  = S_IDLE;
                w_status_nxt = ST_IDLE;
                w_ube_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= ST_IDLE;
            r_addr   <= '0;
            r_dout   <= '0;
            r_ube    <= 1'b1;
        end else begin
            r_status <= w_status_nxt;
            r_addr   <= w_addr_nxt;
            r_dout   <= w_dout_nxt;
            r_ube    <= w_ube_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_eu_done <= 1'b0;
            r_rdata   <= '0;
            r_lo      <= '0;
            r_fdisc   <= 1'b0;
        end else begin
            r_eu_done <= w_eu_final;
            if (w_eu_final)
                r_rdata <= w_rdata_nxt;
            if ((r_state == S_EU_LO) && w_rdy)
                r_lo <= data_in[15:8];
            if (w_arb)
                r_fdisc <= 1'b0;
            else if ((r_state == S_FETCH) && flush)
                r_fdisc <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_n == 2'd2) begin
            r_mem[r_wp]          <= data_in[7:0];
            r_mem[r_wp + AW'(1)] <= data_in[15:8];
        end else if (w_push_n == 2'd1) begin
            r_mem[r_wp] <= data_in[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_pfp   <= 16'hFFF0;
        end else begin
            r_count <= w_cnt_nxt;
            r_pfp   <= w_pfp_nxt;
            if (flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                r_wp <= r_wp + AW'(w_push_n);
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
            end
        end
    end

    assign q_data      = r_mem[r_rp];
    assign q_count     = r_count;
    assign pfp         = r_pfp;
    assign eu_rdata    = r_rdata;
    assign eu_done     = r_eu_done;
    assign data_out    = r_dout;
    assign address_out = r_addr;
    assign bus_status  = r_status;
    assign bus_ube_n   = r_ube;

endmodule

// File: tb/tb_bus_control_unit.sv
// Bench for bus_control_unit: directed scenarios then random traffic,
// all checked against a transaction-level queue/pointer/bus model.
module tb_bus_control_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ps;
    logic        flush;
    logic [15:0] flush_pc;
    logic        suspend;
    logic        q_pop;
    logic [7:0]  q_data;
    logic [3:0]  q_count;
    logic [15:0] pfp;
    logic [2:0]  eu_cmd;
    logic [19:0] eu_addr;
    logic        eu_word;
    logic [15:0] eu_wdata;
    logic [15:0] eu_rdata;
    logic        eu_done;
    logic        readyb;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [19:0] address_out;
    logic [3:0]  bus_status;
    logic        bus_ube_n;

    always #5 clk = ~clk;

    bus_control_unit #(.QUEUE_DEPTH(DEPTH), .FETCH_FREE_MIN(2)) dut (
        .clk(clk), .reset(reset), .ps(ps), .flush(flush),
        .flush_pc(flush_pc), .suspend(suspend), .q_pop(q_pop),
        .q_data(q_data), .q_count(q_count), .pfp(pfp),
        .eu_cmd(eu_cmd), .eu_addr(eu_addr), .eu_word(eu_word),
        .eu_wdata(eu_wdata), .eu_rdata(eu_rdata), .eu_done(eu_done),
        .readyb(readyb), .data_in(data_in), .data_out(data_out),
        .address_out(address_out), .bus_status(bus_status),
        .bus_ube_n(bus_ube_n)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mq[$];
    logic [15:0] mpfp     = 16'hFFF0;
    bit          newc     = 1'b1;
    int          kind     = 0;
    bit          cflush   = 1'b0;
    bit          hi_next  = 1'b0;
    bit          eu_setup = 1'b0;
    bit          last_fin = 1'b0;
    logic [7:0]  lo_b     = 8'h00;
    logic [15:0] exp_rd   = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] stat(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b1001;
            3'd2:    return 4'b1010;
            3'd3:    return 4'b0101;
            3'd4:    return 4'b0110;
            default: return 4'hf;
        endcase
    endfunction

    function automatic bit euv(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    // One clock: classify the bus cycle on its first clock, then advance
    // the model with what the bus and EU did at the edge.
    task automatic tick();
        logic [3:0]  st;
        logic [19:0] ad, ea, fa, ha;
        logic [15:0] dq, din, wd, fpc, pss;
        logic [2:0]  cmd;
        logic        ub, rdy, rs, fl, pp, ew, done, fin;
        st = bus_status; ad = address_out; ub = bus_ube_n; dq = data_out;
        rdy = !readyb; rs = reset; fl = flush; pp = q_pop; din = data_in;
        cmd = eu_cmd; ea = eu_addr; ew = eu_word; wd = eu_wdata;
        fpc = flush_pc; pss = ps;
        fa = {pss, 4'h0} + {4'h0, mpfp};
        ha = ea + 20'd1;
        if (rs) begin
            kind = 0;
        end else if (newc) begin
            cflush = 1'b0;
            if (hi_next) begin
                kind = 3;
                chk("hi_addr", ad, ha);
                chk("hi_ube", ub, 1);
                chk("hi_status", st, stat(cmd));
                if (cmd == 3'd2 || cmd == 3'd4)
                    chk("hi_wdata", dq[7:0], wd[15:8]);
            end else if (eu_setup) begin
                kind = 2;
                chk("lo_addr", ad, ea);
                chk("lo_ube", ub, !(ew | ea[0]));
                chk("lo_status", st, stat(cmd));
                if (cmd == 3'd2 || cmd == 3'd4) begin
                    if (ew && !ea[0]) chk("lo_wdata", dq, wd);
                    else if (ea[0])   chk("lo_wdata", dq[15:8], wd[7:0]);
                    else              chk("lo_wdata", dq[7:0], wd[7:0]);
                end
            end else if (st != 4'hf) begin
                kind = 1;
                chk("fetch_status", st, 4'b1001);
                chk("fetch_addr", ad, fa);
                chk("fetch_ube", ub, 0);
            end else begin
                kind = 0;
            end
        end
        @(posedge clk);
        #1;
        fin = 1'b0;
        if (rs) begin
            mq.delete();
            mpfp = 16'hFFF0; newc = 1'b1; hi_next = 1'b0;
            eu_setup = 1'b0; kind = 0;
        end else begin
            done = (kind != 0) && rdy;
            if (kind == 1 && fl) cflush = 1'b1;
            if (pp && mq.size() != 0 && !fl) void'(mq.pop_front());
            if (fl) begin
                mq.delete();
                mpfp = fpc;
            end else if (kind == 1 && done && !cflush) begin
                if (mpfp[0]) begin
                    mq.push_back(din[15:8]);
                    mpfp = mpfp + 16'd1;
                end else begin
                    mq.push_back(din[7:0]);
                    mq.push_back(din[15:8]);
                    mpfp = mpfp + 16'd2;
                end
                chk("q_room", mq.size() <= DEPTH, 1);
            end
            if (kind == 2 && done) begin
                if (ew && ea[0]) begin
                    lo_b = din[15:8];
                    hi_next = 1'b1;
                end else begin
                    fin = 1'b1;
                    exp_rd = ew ? din
                           : {8'h00, ea[0] ? din[15:8] : din[7:0]};
                end
            end else if (kind == 3 && done) begin
                fin = 1'b1;
                hi_next = 1'b0;
                exp_rd = {din[7:0], lo_b};
            end
            eu_setup = euv(cmd) && !fin;
            newc = (kind == 0) || done;
        end
        chk("q_count", q_count, mq.size());
        chk("pfp", pfp, mpfp);
        if (mq.size() != 0) chk("q_data", q_data, mq[0]);
        chk("eu_done", eu_done, fin);
        if (fin && (cmd == 3'd1 || cmd == 3'd3))
            chk("eu_rdata", eu_rdata, exp_rd);
        last_fin = fin;
    endtask

    initial begin
        bit eu_out;
        int eu_wait;
        reset = 1; ps = 16'hF000; flush = 0; flush_pc = 0; suspend = 0;
        q_pop = 0; eu_cmd = 0; eu_addr = 0; eu_word = 0; eu_wdata = 0;
        readyb = 0; data_in = 0;
        tick();
        tick();
        chk("rst_status", bus_status, 4'hf);
        chk("rst_addr", address_out, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ube", bus_ube_n, 1);
        chk("rst_rdata", eu_rdata, 0);

        // first fetch from reset vector, fill queue to depth
        reset = 0; data_in = 16'h0201;
        tick();
        chk("d1_status", bus_status, 4'b1001);
        chk("d1_addr", address_out, 20'hFFFF0);
        chk("d1_ube", bus_ube_n, 0);
        for (int k = 1; k <= 4; k++) begin
            data_in = 16'h1111 * k[15:0];
            tick();
            chk("d1_count", q_count, 2 * k);
            if (k == 1) chk("d1_addr2", address_out, 20'hFFFF2);
        end
        chk("d1_idle", bus_status, 4'hf);

        // odd flush target: byte fetch then word fetch
        ps = 16'h0000; flush_pc = 16'h0003; flush = 1;
        tick();
        chk("d2_fl_count", q_count, 0);
        chk("d2_fl_pfp", pfp, 16'h0003);
        flush = 0; data_in = 16'hA55A;
        tick();
        chk("d2_addr", address_out, 20'h00003);
        tick();
        chk("d2_count", q_count, 1);
        chk("d2_head", q_data, 8'hA5);
        chk("d2_addr2", address_out, 20'h00004);
        chk("d2_ube2", bus_ube_n, 0);
        data_in = 16'h2211;
        tick();
        chk("d2_count3", q_count, 3);
        data_in = 16'h4433; q_pop = 1;
        tick();
        q_pop = 0;
        chk("d5_pushpop", q_count, 4);
        chk("d5_head", q_data, 8'h11);

        for (int k = 0; k < 10 && bus_status != 4'hf; k++) tick();
        chk("d3_full", q_count, DEPTH);

        // odd-address word read split into two byte cycles
        eu_cmd = 3'd1; eu_addr = 20'h01235; eu_word = 1; data_in = 0;
        tick();
        chk("d3_lo_addr", address_out, 20'h01235);
        chk("d3_lo_ube", bus_ube_n, 0);
        data_in = 16'h12AB;
        tick();
        chk("d3_hi_addr", address_out, 20'h01236);
        chk("d3_hi_ube", bus_ube_n, 1);
        data_in = 16'hCD34;
        tick();
        chk("d3_done", eu_done, 1);
        chk("d3_rdata", eu_rdata, 16'h3412);
        eu_cmd = 0;
        tick();
        chk("d3_done_end", eu_done, 0);

        // flush while a fetch waits on readyb
        readyb = 1; q_pop = 1;
        tick();
        tick();
        chk("d4_fetch", bus_status, 4'b1001);
        q_pop = 0; flush = 1; flush_pc = 16'h0100;
        tick();
        chk("d4_count", q_count, 0);
        flush = 0;
        tick();
        tick();
        chk("d4_wait", bus_status, 4'b1001);
        readyb = 0; suspend = 1;
        tick();
        chk("d4_count_end", q_count, 0);
        chk("d4_pfp", pfp, 16'h0100);
        chk("d4_idle", bus_status, 4'hf);

        q_pop = 1;
        tick();
        chk("d5_pop_empty", q_count, 0);
        q_pop = 0;

        // reset while an EU byte write waits on readyb
        eu_cmd = 3'd2; eu_addr = 20'h00456; eu_word = 0;
        eu_wdata = 16'hBEEF; readyb = 1;
        tick();
        chk("d6_status", bus_status, 4'b1010);
        chk("d6_ube", bus_ube_n, 1);
        chk("d6_dout", data_out, 16'hEFEF);
        tick();
        reset = 1; eu_cmd = 0;
        tick();
        chk("d6_rst_status", bus_status, 4'hf);
        reset = 0; readyb = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("d6_no_done", eu_done, 0);
        end

        ps = 16'($urandom);
        eu_out = 1'b0;
        eu_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            readyb  = ($urandom_range(0, 2) == 0);
            q_pop   = ($urandom_range(0, 2) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            flush_pc = 16'($urandom);
            suspend = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom);
            if (!eu_out && $urandom_range(0, 15) == 0) begin
                eu_cmd   = 3'($urandom_range(1, 4));
                eu_addr  = 20'($urandom);
                eu_word  = 1'($urandom_range(0, 1));
                eu_wdata = 16'($urandom);
                eu_out   = 1'b1;
                eu_wait  = 0;
            end
            tick();
            if (last_fin) begin
                eu_cmd = 0;
                eu_out = 1'b0;
            end else if (eu_out) begin
                eu_wait++;
                if (eu_wait > 400) begin
                    total++;
                    bad++;
                    $error("FAIL eu_timeout: waited %0d cycles want <= 400",
                           eu_wait);
                    eu_cmd = 0;
                    eu_out = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_control_unit.md
Name: bus_control_unit

Overview:
- Parametrised successor to the core's inline prefetch/bus logic: owns the byte-wide prefetch queue, prefetch pointer (PFP) and all bus cycles.
- Arbitrates between instruction prefetch and execution-unit (EU) memory/IO requests.
- Splits odd-address word accesses into two byte cycles.
- Sits between execution_unit and the external 16-bit bus.

Parameters:
QUEUE_DEPTH, 8, prefetch queue size in bytes; power of two, >= 4.
FETCH_FREE_MIN, 2, free queue slots required before an even-address word prefetch starts.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps  in  16  program segment register
flush  in  1  discard queue, reload PFP from flush_pc
flush_pc  in  16  new PFP on flush
suspend  in  1  inhibit starting new prefetches
q_pop  in  1  consume head byte
q_data  out  8  head byte, valid when q_count != 0
q_count  out  $clog2(QUEUE_DEPTH)+1  bytes held
pfp  out  16  next prefetch offset
eu_cmd  in  3  0 idle, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr; held until eu_done
eu_addr  in  20  physical address
eu_word  in  1  1 = word, 0 = byte
eu_wdata  in  16  write data; byte access uses [7:0]
eu_rdata  out  16  read data, valid with eu_done; byte read zero-extended
eu_done  out  1  one-cycle completion pulse
readyb  in  1  active-low bus ready; cycle completes when sampled low
data_in  in  16  bus read data
data_out  out  16  bus write data
address_out  out  20  bus address
bus_status  out  4  f idle, 1001 mem rd/fetch, 1010 mem wr, 0101 io rd, 0110 io wr
bus_ube_n  out  1  active-low upper byte enable

Behaviour:
- Reset values:
  - state IDLE, q_count 0, pfp 16'hFFF0, bus_status 4'hf, address_out 0, data_out 0.
  - eu_done 0, eu_rdata 0, bus_ube_n 1.
- States: IDLE, FETCH, EU_LO, EU_HI.
  - A bus cycle lasts from state entry until readyb is sampled low; minimum 1 cycle.
  - Outputs are registered and stable for the whole cycle.
- Arbitration in IDLE, and at every cycle completion:
  - EU request pending: go to EU_LO.
  - Otherwise, prefetch when all hold: !suspend, !flush, and free slots >= FETCH_FREE_MIN (even pfp) or >= 1 (odd pfp). Go to FETCH.
  - Otherwise: IDLE, bus_status f.
  - Back-to-back cycles have no idle gap.
- FETCH:
  - address_out = {ps,4'b0} + {4'b0,pfp}, mod 2^20.
  - Even pfp: word fetch, bus_ube_n 0. Push data_in[7:0] then [15:8]; pfp += 2.
  - Odd pfp: byte fetch, bus_ube_n 0. Push data_in[15:8] only; pfp += 1.
  - pfp wraps at 16 bits.
- EU byte access, or word access at even address:
  - Single EU_LO cycle.
  - bus_ube_n = !(eu_word | eu_addr[0]).
  - Byte data uses lane eu_addr[0]: writes replicate eu_wdata[7:0] on both lanes; reads pick the lane.
- EU word access at odd address:
  - EU_LO: byte at eu_addr, upper lane.
  - EU_HI: byte at eu_addr+1, lower lane, bus_ube_n 1.
  - eu_rdata = {hi,lo}.
- eu_done pulses the cycle after the final completion. The EU drops or changes eu_cmd that cycle; eu_cmd is not re-sampled until then.
- Queue:
  - Circular buffer.
  - Simultaneous push and pop: q_count = q_count + pushed - 1.
  - q_pop with q_count 0 is ignored.
  - A push never exceeds QUEUE_DEPTH; arbitration guarantees space.
- Flush:
  - Next cycle: q_count 0, pfp = flush_pc.
  - A FETCH in flight completes on the bus, but its data is discarded and pfp is not advanced.
  - flush beats any same-cycle push or pop.
  - EU cycles are unaffected.
- suspend does not abort an in-flight fetch.
- reset mid-cycle: return to IDLE at once, bus_status f, no eu_done.

Test Plan:
- Reset, ps=F000, readyb tied 0 -> first fetch at address FFFF0 (ps 16'hF000, pfp 16'hFFF0), status 1001, ube_n 0; q_count 2,4,6,8 then idle with status f.
- flush_pc=0003 with ps=0, readyb 0 -> byte fetch at 00003, data_in A55A pushes A5; next fetch word at 00004.
- Queue full, eu_cmd=1 word at 01235 -> EU_LO at 01235 (ube_n 0), EU_HI at 01236 (ube_n 1); data 12xx then xx34 -> eu_rdata 3412, eu_done one cycle.
- flush during a FETCH held with readyb=1 for 3 cycles -> q_count stays 0 after completion, pfp equals flush_pc.
- Simultaneous q_pop and word push with q_count 3 -> q_count 4 and head byte ordering preserved; q_pop at q_count 0 -> no change.
- reset asserted while EU_LO waits on readyb -> next cycle bus_status f, eu_done never pulses.
